// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter that shares the 8x8 register file's single read and write port
// among NUM_REQ requesters, and sweeps every entry to zero after reset or on demand.
module regfile_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_write_addr,
  output logic [DW-1:0]         rf_write_data,
  output logic [AW-1:0]         rf_read_addr,
  input  logic [DW-1:0]         rf_read_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_clr_cnt;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_win;
  logic                 r_we_op;
  logic                 r_clear_pend;
  logic                 r_busy;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DW-1:0]        r_rsp_data;
  logic                 r_rf_we;
  logic [AW-1:0]        r_rf_write_addr;
  logic [DW-1:0]        r_rf_write_data;
  logic [AW-1:0]        r_rf_read_addr;

  logic                 w_any;
  logic [PW-1:0]        w_win;
  logic                 w_win_we;
  logic [AW-1:0]        w_win_addr;
  logic [DW-1:0]        w_win_wdata;

  // Scan from the highest offset down so the requester closest to rr_ptr is the last
  // assignment and therefore wins.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        w_any = 1'b1;
        w_win = PW'(idx);
      end
    end
  end

  assign w_win_we    = req_we[w_win];
  assign w_win_addr  = req_addr[w_win*AW +: AW];
  assign w_win_wdata = req_wdata[w_win*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_CLEAR;
      r_clr_cnt       <= '0;
      r_rr_ptr        <= '0;
      r_win           <= '0;
      r_we_op         <= 1'b0;
      r_clear_pend    <= 1'b0;
      r_busy          <= 1'b1;
      r_gnt           <= '0;
      r_rsp_valid     <= '0;
      r_rsp_data      <= '0;
      r_rf_we         <= 1'b0;
      r_rf_write_addr <= '0;
      r_rf_write_data <= '0;
      r_rf_read_addr  <= '0;
    end else begin
      // Ports idle at zero unless this edge sets up a clear write or an access.
      r_gnt           <= '0;
      r_rsp_valid     <= '0;
      r_rf_we         <= 1'b0;
      r_rf_write_addr <= '0;
      r_rf_write_data <= '0;
      r_rf_read_addr  <= '0;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == CW'(DEPTH)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rf_we         <= 1'b1;
            r_rf_write_addr <= r_clr_cnt[AW-1:0];
            r_clr_cnt       <= r_clr_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (r_clear_pend || clear_req) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= '0;
            r_busy       <= 1'b1;
            r_clear_pend <= 1'b0;
          end else if (w_any) begin
            r_win   <= w_win;
            r_we_op <= w_win_we;
            r_gnt   <= ONE << w_win;
            if (w_win_we) begin
              r_rf_we         <= 1'b1;
              r_rf_write_addr <= w_win_addr;
              r_rf_write_data <= w_win_wdata;
            end else begin
              r_rf_read_addr  <= w_win_addr;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we_op) begin
            r_rsp_data  <= rf_read_data;
            r_rsp_valid <= r_gnt;
          end
          r_rr_ptr <= (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);
          if (clear_req) r_clear_pend <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign gnt           = r_gnt;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rf_we         = r_rf_we;
  assign rf_write_addr = r_rf_write_addr;
  assign rf_write_data = r_rf_write_data;
  assign rf_read_addr  = r_rf_read_addr;

endmodule
